// File: rtl/vproc_vreg_wb_arbiter_pkg.sv
// Shared constants and helpers for the vector-register write-back arbiter.
// The upper VREG_IDX_W bits of a register-file row address select the vreg.
package vproc_vreg_wb_arbiter_pkg;

  localparam int unsigned VREG_IDX_W = 5;
  localparam int unsigned VREG_CNT   = 32;

  function automatic logic [VREG_CNT-1:0] vreg_onehot(input logic [VREG_IDX_W-1:0] idx);
    return VREG_CNT'(1) << idx;
  endfunction

endpackage

// File: rtl/vproc_wb_fifo.sv
// Single-clock circular-buffer FIFO holding one source's pending writes.
// Exposes every slot's address and occupancy so the top can build the pending-vreg mask.
module vproc_wb_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned AW    = 7,
  parameter  int unsigned PW    = 576,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                       clk_i,
  input  logic                       async_rst_ni,
  input  logic                       push_i,
  input  logic [AW-1:0]              push_addr_i,
  input  logic [PW-1:0]              push_payload_i,
  input  logic                       pop_i,
  output logic [CNT_W-1:0]           count_o,
  output logic [AW-1:0]              head_addr_o,
  output logic [PW-1:0]              head_payload_o,
  output logic [DEPTH-1:0]           entry_vld_o,
  output logic [DEPTH-1:0][AW-1:0]   entry_addr_o
);

  logic [AW-1:0]    r_addr_mem [DEPTH];
  logic [PW-1:0]    r_pay_mem  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop_i)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (push_i && !pop_i)      r_count <= r_count + CNT_W'(1);
      else if (pop_i && !push_i) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_addr_mem[r_wr_ptr] <= push_addr_i;
      r_pay_mem[r_wr_ptr]  <= push_payload_i;
    end
  end

  assign count_o        = r_count;
  assign head_addr_o    = r_addr_mem[r_rd_ptr];
  assign head_payload_o = r_pay_mem[r_rd_ptr];

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] w_off;
    assign w_off           = PTR_W'(i) - r_rd_ptr;
    assign entry_vld_o[i]  = {1'b0, w_off} < r_count;
    assign entry_addr_o[i] = r_addr_mem[i];
  end

endmodule

// File: rtl/vproc_vreg_wb_arbiter.sv
// Write-back arbiter: per-source FIFOs, round-robin pick of one write per cycle,
// registered onto the register-file write port, plus a pending-write mask per vreg.
module vproc_vreg_wb_arbiter
  import vproc_vreg_wb_arbiter_pkg::*;
#(
  parameter int unsigned SRC_CNT    = 3,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned PORT_W     = 512,
  parameter int unsigned ADDR_W     = 7
) (
  input  logic                                 clk_i,
  input  logic                                 async_rst_ni,
  // Transfer on src_valid_i[s] & src_ready_o[s] at a rising edge. Ready reflects FIFO
  // occupancy only; the payload is held stable while valid is high and ready is low.
  input  logic [SRC_CNT-1:0]                   src_valid_i,
  output logic [SRC_CNT-1:0]                   src_ready_o,
  input  logic [SRC_CNT-1:0][ADDR_W-1:0]       src_addr_i,
  input  logic [SRC_CNT-1:0][PORT_W-1:0]       src_data_i,
  input  logic [SRC_CNT-1:0][PORT_W/8-1:0]     src_be_i,
  output logic [ADDR_W-1:0]                    wr_addr_o,
  output logic [PORT_W-1:0]                    wr_data_o,
  output logic [PORT_W/8-1:0]                  wr_be_o,
  output logic                                 wr_we_o,
  output logic [VREG_CNT-1:0]                  pend_vreg_o,
  output logic                                 idle_o
);

  localparam int unsigned BE_W  = PORT_W / 8;
  localparam int unsigned PAY_W = PORT_W + BE_W;
  localparam int unsigned IDX_W = $clog2(SRC_CNT);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [SRC_CNT-1:0][CNT_W-1:0]                   w_count;
  logic [SRC_CNT-1:0]                              w_push;
  logic [SRC_CNT-1:0]                              w_pop;
  logic [SRC_CNT-1:0]                              w_nonempty;
  logic [SRC_CNT-1:0][ADDR_W-1:0]                  w_head_addr;
  logic [SRC_CNT-1:0][PAY_W-1:0]                   w_head_pay;
  logic [SRC_CNT-1:0][FIFO_DEPTH-1:0]              w_ent_vld;
  logic [SRC_CNT-1:0][FIFO_DEPTH-1:0][ADDR_W-1:0]  w_ent_addr;

  logic              w_gnt_vld;
  logic [IDX_W-1:0]  w_gnt_idx;
  int unsigned       w_cand;
  logic [VREG_CNT-1:0] w_pend;

  logic [IDX_W-1:0]  r_rr_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [PORT_W-1:0] r_data;
  logic [BE_W-1:0]   r_be;

  for (genvar s = 0; s < SRC_CNT; s++) begin : g_src
    // A full FIFO refuses a push even if it pops in the same cycle.
    assign src_ready_o[s] = w_count[s] < CNT_W'(FIFO_DEPTH);
    assign w_nonempty[s]  = w_count[s] != '0;
    assign w_push[s]      = src_valid_i[s] & src_ready_o[s];
    assign w_pop[s]       = w_gnt_vld && (w_gnt_idx == IDX_W'(s));

    vproc_wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (ADDR_W),
      .PW    (PAY_W)
    ) u_fifo (
      .clk_i          (clk_i),
      .async_rst_ni   (async_rst_ni),
      .push_i         (w_push[s]),
      .push_addr_i    (src_addr_i[s]),
      .push_payload_i ({src_be_i[s], src_data_i[s]}),
      .pop_i          (w_pop[s]),
      .count_o        (w_count[s]),
      .head_addr_o    (w_head_addr[s]),
      .head_payload_o (w_head_pay[s]),
      .entry_vld_o    (w_ent_vld[s]),
      .entry_addr_o   (w_ent_addr[s])
    );
  end

  // First non-empty source at or after the round-robin pointer, wrapping.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = 0;
    for (int unsigned k = 0; k < SRC_CNT; k++) begin
      w_cand = (32'(r_rr_ptr) + k) % SRC_CNT;
      if (!w_gnt_vld && w_nonempty[IDX_W'(w_cand)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IDX_W'(w_cand);
      end
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_rr_ptr <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_be     <= '0;
    end else begin
      r_we <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_addr           <= w_head_addr[w_gnt_idx];
        {r_be, r_data}   <= w_head_pay[w_gnt_idx];
        r_rr_ptr         <= (w_gnt_idx == IDX_W'(SRC_CNT - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
      end
    end
  end

  // A vreg stays pending until its last write has left the output register.
  always_comb begin
    w_pend = '0;
    for (int s = 0; s < SRC_CNT; s++) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        if (w_ent_vld[s][e]) w_pend = w_pend | vreg_onehot(w_ent_addr[s][e][ADDR_W-1 -: VREG_IDX_W]);
      end
    end
    if (r_we) w_pend = w_pend | vreg_onehot(r_addr[ADDR_W-1 -: VREG_IDX_W]);
  end

  assign wr_we_o     = r_we;
  assign wr_addr_o   = r_addr;
  assign wr_data_o   = r_data;
  assign wr_be_o     = r_be;
  assign pend_vreg_o = w_pend;
  assign idle_o      = ~|w_nonempty & ~r_we;

endmodule

// File: tb/tb_vproc_vreg_wb_arbiter.sv
// Bench for vproc_vreg_wb_arbiter: random sources against a queue-based reference model.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_vproc_vreg_wb_arbiter;

  localparam int SRC_CNT    = 3;
  localparam int FIFO_DEPTH = 2;
  localparam int PORT_W     = 512;
  localparam int ADDR_W     = 7;
  localparam int BE_W       = PORT_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PORT_W-1:0] data;
    logic [BE_W-1:0]   be;
  } req_t;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b0;
  logic [SRC_CNT-1:0]                src_valid_i = '0;
  logic [SRC_CNT-1:0]                src_ready_o;
  logic [SRC_CNT-1:0][ADDR_W-1:0]    src_addr_i = '0;
  logic [SRC_CNT-1:0][PORT_W-1:0]    src_data_i = '0;
  logic [SRC_CNT-1:0][BE_W-1:0]      src_be_i = '0;
  logic [ADDR_W-1:0]                 wr_addr_o;
  logic [PORT_W-1:0]                 wr_data_o;
  logic [BE_W-1:0]                   wr_be_o;
  logic                              wr_we_o;
  logic [31:0]                       pend_vreg_o;
  logic                              idle_o;

  int checks = 0;
  int errors = 0;
  logic [4:0] seq [SRC_CNT];
  logic be_zero = 1'b0;
  logic [ADDR_W-1:0] exp_q [$];

  // Reference model: one queue per source, round-robin pointer, expected write port.
  req_t m_q [SRC_CNT][$];
  int m_rr = 0;
  int m_g;
  int m_idx;
  logic [SRC_CNT-1:0] m_acc;
  req_t m_r;
  logic m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [PORT_W-1:0] m_data;
  logic [BE_W-1:0] m_be;

  vproc_vreg_wb_arbiter #(
    .SRC_CNT(SRC_CNT), .FIFO_DEPTH(FIFO_DEPTH), .PORT_W(PORT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk), .async_rst_ni(rst_n),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_addr_i(src_addr_i), .src_data_i(src_data_i), .src_be_i(src_be_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_be_o(wr_be_o), .wr_we_o(wr_we_o),
    .pend_vreg_o(pend_vreg_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SRC_CNT; s++) m_q[s].delete();
      m_rr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_be = '0;
    end else begin
      for (int s = 0; s < SRC_CNT; s++) m_acc[s] = src_valid_i[s] && (m_q[s].size() < FIFO_DEPTH);
      m_g = -1;
      for (int k = 0; k < SRC_CNT; k++) begin
        m_idx = (m_rr + k) % SRC_CNT;
        if (m_g < 0 && m_q[m_idx].size() > 0) m_g = m_idx;
      end
      if (m_g >= 0) begin
        m_r = m_q[m_g].pop_front();
        m_we = 1'b1; m_addr = m_r.addr; m_data = m_r.data; m_be = m_r.be;
        m_rr = (m_g + 1) % SRC_CNT;
      end else begin
        m_we = 1'b0;
      end
      for (int s = 0; s < SRC_CNT; s++) begin
        if (m_acc[s]) begin
          m_r.addr = src_addr_i[s]; m_r.data = src_data_i[s]; m_r.be = src_be_i[s];
          m_q[s].push_back(m_r);
        end
      end
    end
  end

  function automatic logic [31:0] model_pend();
    logic [31:0] p;
    p = '0;
    for (int s = 0; s < SRC_CNT; s++)
      for (int i = 0; i < m_q[s].size(); i++) p[m_q[s][i].addr[6:2]] = 1'b1;
    if (m_we) p[m_addr[6:2]] = 1'b1;
    return p;
  endfunction

  function automatic logic [SRC_CNT-1:0] model_ready();
    logic [SRC_CNT-1:0] r;
    for (int s = 0; s < SRC_CNT; s++) r[s] = (m_q[s].size() < FIFO_DEPTH);
    return r;
  endfunction

  function automatic logic model_idle();
    logic e;
    e = !m_we;
    for (int s = 0; s < SRC_CNT; s++) if (m_q[s].size() != 0) e = 1'b0;
    return e;
  endfunction

  function automatic logic [PORT_W-1:0] rand_data();
    logic [PORT_W-1:0] d;
    for (int i = 0; i < PORT_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Driver: call at a falling edge; new payload only after a handshake or when idle.
  task automatic drive_cycle(input logic [SRC_CNT-1:0] want);
    logic [SRC_CNT-1:0] hs;
    hs = src_valid_i & src_ready_o;
    @(posedge clk);
    #1;
    for (int s = 0; s < SRC_CNT; s++) begin
      if (hs[s] || !src_valid_i[s]) begin
        if (want[s]) begin
          src_valid_i[s] = 1'b1;
          src_addr_i[s]  = {2'(s), seq[s]};
          seq[s]         = seq[s] + 5'd1;
          src_data_i[s]  = rand_data();
          src_be_i[s]    = be_zero ? '0 : {$urandom, $urandom};
        end else begin
          src_valid_i[s] = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < SRC_CNT; s++) seq[s] = 5'(s * 7);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (src_ready_o !== 3'b111) begin errors++; $display("FAIL rst_ready got=%b exp=111", src_ready_o); end
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL rst_idle got=%b exp=1", idle_o); end
    checks++; if (wr_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", wr_we_o); end
    checks++; if (pend_vreg_o !== 32'h0) begin errors++; $display("FAIL rst_pend got=%h exp=0", pend_vreg_o); end
    checks++; if (wr_addr_o !== '0) begin errors++; $display("FAIL rst_addr got=%h exp=0", wr_addr_o); end
    checks++; if (wr_data_o !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", wr_data_o); end
    checks++; if (wr_be_o !== '0) begin errors++; $display("FAIL rst_be got=%h exp=0", wr_be_o); end
  endtask

  task automatic test_fairness();
    int k;
    k = 0;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      drive_cycle(3'b111);
      @(negedge clk);
      if (i >= 2) begin
        checks++; if (wr_we_o !== 1'b1) begin errors++; $display("FAIL fair_bubble cyc=%0d got=%b exp=1", i, wr_we_o); end
        checks++; if (wr_addr_o[6:5] !== 2'(k % 3)) begin errors++; $display("FAIL fair_order write=%0d got=%0d exp=%0d", k, wr_addr_o[6:5], k % 3); end
        k++;
      end
      checks++; if (wr_addr_o !== m_addr) begin errors++; $display("FAIL fair_addr got=%h exp=%h", wr_addr_o, m_addr); end
      checks++; if (wr_data_o !== m_data) begin errors++; $display("FAIL fair_data got=%h exp=%h", wr_data_o, m_data); end
      checks++; if (wr_be_o !== m_be) begin errors++; $display("FAIL fair_be got=%h exp=%h", wr_be_o, m_be); end
      checks++; if (pend_vreg_o !== model_pend()) begin errors++; $display("FAIL fair_pend got=%h exp=%h", pend_vreg_o, model_pend()); end
      checks++; if (src_ready_o !== model_ready()) begin errors++; $display("FAIL fair_ready got=%b exp=%b", src_ready_o, model_ready()); end
    end
    for (int i = 0; i < 12; i++) begin
      drive_cycle(3'b000);
      @(negedge clk);
      checks++; if (wr_we_o !== m_we) begin errors++; $display("FAIL drain_we got=%b exp=%b", wr_we_o, m_we); end
      checks++; if (wr_addr_o !== m_addr) begin errors++; $display("FAIL drain_addr got=%h exp=%h", wr_addr_o, m_addr); end
      checks++; if (pend_vreg_o !== model_pend()) begin errors++; $display("FAIL drain_pend got=%h exp=%h", pend_vreg_o, model_pend()); end
    end
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL drain_idle got=%b exp=1", idle_o); end
  endtask

  task automatic test_single_write();
    @(posedge clk);
    #1;
    src_valid_i[0] = 1'b1; src_addr_i[0] = 7'h0A; src_data_i[0] = {64{8'hA5}}; src_be_i[0] = '1;
    @(posedge clk);
    #1 src_valid_i[0] = 1'b0;
    @(negedge clk);
    checks++; if (pend_vreg_o !== 32'h4) begin errors++; $display("FAIL single_pend_n1 got=%h exp=00000004", pend_vreg_o); end
    checks++; if (wr_we_o !== 1'b0) begin errors++; $display("FAIL single_we_n1 got=%b exp=0", wr_we_o); end
    @(negedge clk);
    checks++; if (wr_we_o !== 1'b1) begin errors++; $display("FAIL single_we_n2 got=%b exp=1", wr_we_o); end
    checks++; if (wr_addr_o !== 7'h0A) begin errors++; $display("FAIL single_addr got=%h exp=0a", wr_addr_o); end
    checks++; if (wr_data_o !== {64{8'hA5}}) begin errors++; $display("FAIL single_data got=%h", wr_data_o); end
    checks++; if (wr_be_o !== {BE_W{1'b1}}) begin errors++; $display("FAIL single_be got=%h exp=all ones", wr_be_o); end
    checks++; if (pend_vreg_o !== 32'h4) begin errors++; $display("FAIL single_pend_n2 got=%h exp=00000004", pend_vreg_o); end
    @(negedge clk);
    checks++; if (wr_we_o !== 1'b0) begin errors++; $display("FAIL single_we_n3 got=%b exp=0", wr_we_o); end
    checks++; if (pend_vreg_o !== 32'h0) begin errors++; $display("FAIL single_pend_n3 got=%h exp=0", pend_vreg_o); end
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL single_idle got=%b exp=1", idle_o); end
  endtask

  task automatic test_zero_be();
    logic [PORT_W-1:0] d;
    d = rand_data();
    @(posedge clk);
    #1;
    src_valid_i[1] = 1'b1; src_addr_i[1] = 7'h3C; src_data_i[1] = d; src_be_i[1] = '0;
    @(posedge clk);
    #1 src_valid_i[1] = 1'b0;
    @(negedge clk);
    checks++; if (pend_vreg_o !== 32'h8000) begin errors++; $display("FAIL zbe_pend_n1 got=%h exp=00008000", pend_vreg_o); end
    @(negedge clk);
    checks++; if (wr_we_o !== 1'b1) begin errors++; $display("FAIL zbe_we got=%b exp=1", wr_we_o); end
    checks++; if (wr_be_o !== '0) begin errors++; $display("FAIL zbe_be got=%h exp=0", wr_be_o); end
    checks++; if (wr_addr_o !== 7'h3C) begin errors++; $display("FAIL zbe_addr got=%h exp=3c", wr_addr_o); end
    checks++; if (wr_data_o !== d) begin errors++; $display("FAIL zbe_data got=%h exp=%h", wr_data_o, d); end
    @(negedge clk);
    checks++; if (wr_we_o !== 1'b0) begin errors++; $display("FAIL zbe_we_after got=%b exp=0", wr_we_o); end
    checks++; if (pend_vreg_o !== 32'h0) begin errors++; $display("FAIL zbe_pend_after got=%h exp=0", pend_vreg_o); end
  endtask

  task automatic test_backpressure();
    logic saw_full;
    logic [ADDR_W-1:0] e;
    saw_full = 1'b0;
    exp_q.delete();
    @(negedge clk);
    for (int i = 0; i < 26; i++) begin
      if (src_valid_i[1] && src_ready_o[1]) exp_q.push_back(src_addr_i[1]);
      drive_cycle(i < 16 ? 3'b011 : 3'b000);
      @(negedge clk);
      if (!src_ready_o[1]) saw_full = 1'b1;
      checks++; if (src_ready_o !== model_ready()) begin errors++; $display("FAIL bp_ready got=%b exp=%b", src_ready_o, model_ready()); end
      checks++; if (wr_we_o !== m_we) begin errors++; $display("FAIL bp_we got=%b exp=%b", wr_we_o, m_we); end
      checks++; if (wr_data_o !== m_data) begin errors++; $display("FAIL bp_data got=%h exp=%h", wr_data_o, m_data); end
      checks++; if (pend_vreg_o !== model_pend()) begin errors++; $display("FAIL bp_pend got=%h exp=%h", pend_vreg_o, model_pend()); end
      if (wr_we_o === 1'b1 && wr_addr_o[6:5] === 2'd1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra got=%h exp=none", wr_addr_o);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr_o !== e) begin errors++; $display("FAIL bp_order got=%h exp=%h", wr_addr_o, e); end
        end
      end
    end
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_full_seen got=%b exp=1", saw_full); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_lost got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int npush;
    int nwr;
    logic [ADDR_W-1:0] e;
    npush = 0;
    nwr = 0;
    exp_q.delete();
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      if (src_valid_i[2] && src_ready_o[2]) begin exp_q.push_back(src_addr_i[2]); npush++; end
      drive_cycle(npush < 10 ? 3'b100 : 3'b000);
      @(negedge clk);
      checks++; if (wr_we_o !== m_we) begin errors++; $display("FAIL wrap_we got=%b exp=%b", wr_we_o, m_we); end
      checks++; if (wr_data_o !== m_data) begin errors++; $display("FAIL wrap_data got=%h exp=%h", wr_data_o, m_data); end
      checks++; if (wr_be_o !== m_be) begin errors++; $display("FAIL wrap_be got=%h exp=%h", wr_be_o, m_be); end
      checks++; if (idle_o !== model_idle()) begin errors++; $display("FAIL wrap_idle got=%b exp=%b", idle_o, model_idle()); end
      if (wr_we_o === 1'b1) begin
        nwr++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL wrap_extra got=%h exp=none", wr_addr_o);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr_o !== e) begin errors++; $display("FAIL wrap_order got=%h exp=%h", wr_addr_o, e); end
        end
      end
    end
    checks++; if (nwr != 10) begin errors++; $display("FAIL wrap_count got=%0d exp=10", nwr); end
  endtask

  task automatic test_random();
    @(negedge clk);
    for (int i = 0; i < 70; i++) begin
      be_zero = ($urandom_range(0, 7) == 0);
      drive_cycle(i < 60 ? 3'($urandom_range(0, 7)) : 3'b000);
      @(negedge clk);
      checks++; if (wr_we_o !== m_we) begin errors++; $display("FAIL rnd_we got=%b exp=%b", wr_we_o, m_we); end
      checks++; if (wr_addr_o !== m_addr) begin errors++; $display("FAIL rnd_addr got=%h exp=%h", wr_addr_o, m_addr); end
      checks++; if (wr_data_o !== m_data) begin errors++; $display("FAIL rnd_data got=%h exp=%h", wr_data_o, m_data); end
      checks++; if (wr_be_o !== m_be) begin errors++; $display("FAIL rnd_be got=%h exp=%h", wr_be_o, m_be); end
      checks++; if (pend_vreg_o !== model_pend()) begin errors++; $display("FAIL rnd_pend got=%h exp=%h", pend_vreg_o, model_pend()); end
      checks++; if (src_ready_o !== model_ready()) begin errors++; $display("FAIL rnd_ready got=%b exp=%b", src_ready_o, model_ready()); end
      checks++; if (idle_o !== model_idle()) begin errors++; $display("FAIL rnd_idle got=%b exp=%b", idle_o, model_idle()); end
    end
    be_zero = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(3'b111);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    src_valid_i = '0;
    #1;
    checks++; if (wr_we_o !== 1'b0) begin errors++; $display("FAIL mid_rst_we got=%b exp=0", wr_we_o); end
    checks++; if (pend_vreg_o !== 32'h0) begin errors++; $display("FAIL mid_rst_pend got=%h exp=0", pend_vreg_o); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (src_ready_o !== 3'b111) begin errors++; $display("FAIL mid_rst_ready got=%b exp=111", src_ready_o); end
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL mid_rst_idle got=%b exp=1", idle_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (wr_we_o !== 1'b0) begin errors++; $display("FAIL mid_rst_nowrite cyc=%0d got=%b exp=0", i, wr_we_o); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fairness();
    test_single_write();
    test_zero_be();
    test_backpressure();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
